fifo_packer: RTL

Width up-converter that drains a first-word-fall-through FIFO read port (r_empty / r_data / r_inc) and packs RATIO consecutive narrow words into one wide word. The wide word is presented on a valid/ready output with a one-entry output register. It sits directly downstream of the synchronous FIFO, e.g. packing 8-bit pixel bytes into 16-bit SRAM write words. Sustains one narrow word per cycle while the sink keeps up.

---
 rtl/packer_pkg.sv | 15 +
 rtl/fifo_packer_if.sv | 39 +++
 rtl/fifo_packer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/packer_pkg.sv
// packer_pkg: helpers shared by the width converters (this up-packer and a
// future down-converter).
//   lane_cnt_w(ratio) : width of a "number of populated lanes" field (0..ratio)
//   lane_idx_w(ratio) : width of a lane index (0..ratio-1), at least 1 bit
package packer_pkg;

    function automatic int lane_cnt_w(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    function automatic int lane_idx_w(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/fifo_packer_if.sv
// fifo_packer_if: bundles the FWFT FIFO read port, the flush request and the
// wide-word output stream of fifo_packer.
//   r_empty/r_data/r_inc : FIFO read port (r_data valid while !r_empty)
//   flush/flush_done     : partial-word flush request and its completion pulse
//   o_valid/o_ready      : output handshake for o_data/o_lanes
// Output handshake: a word transfers on a clock edge where o_valid && o_ready;
// once o_valid is high, o_data and o_lanes hold steady until that edge, and
// o_valid never depends combinationally on o_ready.
// Modports: master = packer side, slave = FIFO/sink side.
interface fifo_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 2
);
    import packer_pkg::*;

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int LANE_W    = lane_cnt_w(RATIO);

    logic                 r_empty;
    logic [IN_WIDTH-1:0]  r_data;
    logic                 r_inc;
    logic                 flush;
    logic                 flush_done;
    logic                 o_valid;
    logic                 o_ready;
    logic [OUT_WIDTH-1:0] o_data;
    logic [LANE_W-1:0]    o_lanes;

    modport master (
        input  r_empty, r_data, flush, o_ready,
        output r_inc, flush_done, o_valid, o_data, o_lanes
    );

    modport slave (
        output r_empty, r_data, flush, o_ready,
        input  r_inc, flush_done, o_valid, o_data, o_lanes
    );

endinterface

// File: rtl/fifo_packer.sv
// fifo_packer: drains a first-word-fall-through FIFO and packs RATIO narrow
// words into one wide word held in a one-entry output register.
// The first popped word lands in the lowest lane of o_data.
// Parameters: IN_WIDTH (narrow width), RATIO (>= 2 words per wide word).
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : fifo_packer_if.master (FIFO read port, flush, output stream)
// Optional feature macro FIFO_PACKER_FLUSH_EN: enables flush of a partial
// word (o_lanes < RATIO, unused upper lanes zero). Without it flush is
// ignored and flush_done stays 0.
module fifo_packer
    import packer_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_packer_if.master bus
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int LANE_W    = lane_cnt_w(RATIO);
    localparam int IDX_W     = lane_idx_w(RATIO);

    localparam logic [IDX_W-1:0]  LAST_LANE  = IDX_W'(RATIO - 1);
    localparam logic [LANE_W-1:0] FULL_LANES = LANE_W'(RATIO);

    logic [IDX_W-1:0]     lane_cnt;
    logic [IN_WIDTH-1:0]  acc [RATIO-1];
    logic                 valid_q;
    logic [OUT_WIDTH-1:0] data_q;
    logic [LANE_W-1:0]    lanes_q;
    logic                 flush_done_q;

    logic                 slot_free;
    logic                 last_lane;
    logic                 accept;
    logic                 flush_take;
    logic                 flush_event;
    logic [OUT_WIDTH-1:0] full_word;
    logic [OUT_WIDTH-1:0] part_word;

    assign slot_free = !valid_q || bus.o_ready;
    assign last_lane = (lane_cnt == LAST_LANE);
    // Gated with rst_n so the FIFO is never popped while held in reset.
    assign accept    = rst_n && !bus.r_empty && (!last_lane || slot_free) && !flush_take;

`ifdef FIFO_PACKER_FLUSH_EN
    // A flush is ignored in the cycle flush_done is high: the requester is
    // still holding flush then and must not trigger a second service.
    assign flush_take  = bus.flush && !flush_done_q && (lane_cnt != '0) && slot_free;
    assign flush_event = bus.flush && !flush_done_q && ((lane_cnt == '0) || slot_free);
`else
    logic unused_flush;
    assign unused_flush = bus.flush;
    assign flush_take   = 1'b0;
    assign flush_event  = 1'b0;
`endif

    // full_word: accumulator plus the incoming word in the top lane.
    // part_word: only the populated lanes; stale lanes from earlier words
    // are masked to zero.
    always_comb begin
        full_word = '0;
        part_word = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            full_word[i*IN_WIDTH +: IN_WIDTH] = acc[i];
            if (IDX_W'(i) < lane_cnt) begin
                part_word[i*IN_WIDTH +: IN_WIDTH] = acc[i];
            end
        end
        full_word[(RATIO-1)*IN_WIDTH +: IN_WIDTH] = bus.r_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt     <= '0;
            for (int i = 0; i < RATIO - 1; i++) begin
                acc[i] <= '0;
            end
            valid_q      <= 1'b0;
            data_q       <= '0;
            lanes_q      <= '0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= flush_event;
            if (accept && last_lane) begin
                // Replaces any word draining this cycle, so no bubble.
                data_q   <= full_word;
                lanes_q  <= FULL_LANES;
                valid_q  <= 1'b1;
                lane_cnt <= '0;
            end else if (flush_take) begin
                data_q   <= part_word;
                lanes_q  <= LANE_W'(lane_cnt);
                valid_q  <= 1'b1;
                lane_cnt <= '0;
            end else begin
                if (valid_q && bus.o_ready) begin
                    valid_q <= 1'b0;
                end
                if (accept) begin
                    for (int i = 0; i < RATIO - 1; i++) begin
                        if (lane_cnt == IDX_W'(i)) begin
                            acc[i] <= bus.r_data;
                        end
                    end
                    lane_cnt <= lane_cnt + IDX_W'(1);
                end
            end
        end
    end

    assign bus.r_inc      = accept;
    assign bus.o_valid    = valid_q;
    assign bus.o_data     = data_q;
    assign bus.o_lanes    = lanes_q;
    assign bus.flush_done = flush_done_q;

endmodule
